button_conditioner: RTL and testbench

//  Input-side front end for the push button that feeds top: synchronises the raw pad,

---
 rtl/button_pkg.sv | 27 ++
 rtl/button_conditioner_sync.sv | 31 +++
 rtl/button_conditioner.sv | 124 ++++++++++++
 tb/tb_button_conditioner.sv | 125 ++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// ============================================================================
// Module : button_pkg
// Desc   : Shared state type and counter-width helpers for button_conditioner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_e;

  // Debounce counter must be able to hold the terminal count itself.
  function automatic int dcnt_width(input int debounce_cycles);
    return (debounce_cycles < 2) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

  function automatic int hcnt_width(input int long_press_cycles);
    return (long_press_cycles < 3) ? 1 : $clog2(long_press_cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_sync.sv
// ============================================================================
// Module : sync_ff
// Desc   : Reset-to-0 multi-flop synchroniser for an asynchronous input pad.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module : button_conditioner
// Desc   : Synchronise, debounce and classify a push button into 1-cycle events.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_short_press,
  output logic o_long_press
);

  localparam int DW = dcnt_width(DEBOUNCE_CYCLES);
  localparam int HW = hcnt_width(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] C_DCNT_TERM = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] C_HCNT_TERM = HW'(LONG_PRESS_CYCLES - 1);

  logic          w_sync;
  logic          w_toggle;
  logic          w_rise;
  logic          w_fall;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_short_press;
  logic          r_long_press;
  btn_state_e    r_state;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (i_button),
    .o_q     (w_sync)
  );

  // Once the count reaches terminal the level change is committed.
  assign w_toggle = (r_dcnt == C_DCNT_TERM);
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle &&  r_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dcnt  <= '0;
      r_level <= 1'b0;
    end else if (w_toggle) begin
      r_dcnt  <= '0;
      r_level <= ~r_level;
    end else if (w_sync != r_level) begin
      r_dcnt  <= r_dcnt + DW'(1);
    end else begin
      r_dcnt  <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_hcnt        <= '0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_short_press <= 1'b0;
      r_long_press  <= 1'b0;
    end else begin
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_short_press <= 1'b0;
      r_long_press  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PRESSED;
            r_press <= 1'b1;
            r_hcnt  <= '0;
          end
        end
        PRESSED: begin
          // A fall coinciding with the long-press terminal counts as a short press.
          if (w_fall) begin
            r_state       <= IDLE;
            r_release     <= 1'b1;
            r_short_press <= 1'b1;
          end else if (r_hcnt == C_HCNT_TERM) begin
            r_state      <= LONG_HELD;
            r_long_press <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end
        LONG_HELD: begin
          if (w_fall) begin
            r_state   <= IDLE;
            r_release <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_level       = r_level;
  assign o_press       = r_press;
  assign o_release     = r_release;
  assign o_short_press = r_short_press;
  assign o_long_press  = r_long_press;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module : tb_button_conditioner
// Desc   : Directed self-checking bench for button_conditioner (default params).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  logic clk;
  logic reset_n;
  logic button;
  logic level;
  logic press;
  logic rel;
  logic short_press;
  logic long_press;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  button_conditioner dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_button      (button),
    .o_level       (level),
    .o_press       (press),
    .o_release     (rel),
    .o_short_press (short_press),
    .o_long_press  (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, level,       1'b0);
    chk({tag, "_press"}, press,       1'b0);
    chk({tag, "_rel"},   rel,         1'b0);
    chk({tag, "_short"}, short_press, 1'b0);
    chk({tag, "_long"},  long_press,  1'b0);
  endtask

  // Cycle c drives the button before posedge c and checks just after it.
  // Expected event cycles of -1 mean the event must never fire in this window.
  task automatic run(input int total, input int hi_to, input bit chatter,
                     input int ep, input int er, input int es, input int el,
                     input bit lvl0);
    logic exp_lvl;
    for (int c = 0; c < total; c++) begin
      if (chatter) button = (c >= 20) || ((c % 4) < 2);
      else         button = (c < hi_to);
      @(posedge clk);
      #1;
      cyc = c;
      if (lvl0) exp_lvl = (er < 0) || (c < er);
      else      exp_lvl = (ep >= 0) && (c >= ep) && ((er < 0) || (c < er));
      chk("press", press,       c == ep);
      chk("rel",   rel,         c == er);
      chk("short", short_press, c == es);
      chk("long",  long_press,  c == el);
      chk("level", level,       exp_lvl);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    button  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");

    // Reset release with button already held
    reset_n = 1'b1;
    run(20, 10, 1'b0, 6, 16, 16, -1, 1'b0);

    // Single-cycle tap is filtered out
    run(100, 1, 1'b0, -1, -1, -1, -1, 1'b0);

    // Short hold
    run(20, 10, 1'b0, 6, 16, 16, -1, 1'b0);

    // Long hold
    run(64, 50, 1'b0, 6, 56, -1, 38, 1'b0);

    // Fall accepted on the long-press terminal cycle: fall wins
    run(45, 32, 1'b0, 6, 38, 38, -1, 1'b0);

    // Fall one cycle after terminal: long press then plain release
    run(45, 33, 1'b0, 6, 39, -1, 38, 1'b0);

    // Chatter, then stable high; release afterwards as a short press
    run(40, 0, 1'b1, 26, -1, -1, -1, 1'b0);
    run(12, 0, 1'b0, -1, 6, 6, -1, 1'b1);

    // Reset in the middle of a long hold
    run(20, 1000, 1'b0, 6, -1, -1, -1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid1");
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid2");
    reset_n = 1'b1;
    run(20, 10, 1'b0, 6, 16, 16, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
